// File: rtl/control_croma_multi.sv
// Tone / chroma adjustment control: one saturating tone register plus NCH
// saturating colour channels, stepped by UP/down presses with auto-repeat.
module control_croma_multi #(
  parameter int                     TONE_W     = 8,
  parameter logic [TONE_W-1:0]      TONE_RST   = 8'hA4,
  parameter int                     COLOR_W    = 3,
  parameter int                     NCH        = 2,
  parameter logic [NCH*COLOR_W-1:0] COLOR_RST  = {3'b111, 3'b000},
  parameter int                     SEL_W      = 1,
  parameter int                     REPEAT_DLY = 25_000_000,
  parameter int                     REPEAT_PER = 5_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Tono,
  input  logic                     color,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     UP,
  input  logic                     down,
  output logic [TONE_W-1:0]        ton,
  output logic [NCH*COLOR_W-1:0]   colors,
  output logic                     changed,
  output logic                     at_limit
);

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    dir_up;
  logic                    up_hist;
  logic                    dn_hist;

  logic                    up_req;
  logic                    dn_req;
  logic                    exit_req;
  logic                    step;
  logic                    step_up;
  logic                    tgt_valid;
  logic                    tgt_moved;
  logic [TONE_W-1:0]       tone_nxt;
  logic [NCH*COLOR_W-1:0]  colors_nxt;

  function automatic logic [TONE_W-1:0] tone_sat_step(input logic [TONE_W-1:0] v,
                                                      input logic up);
    if (up)
      return (v == '1) ? v : v + TONE_W'(1);
    return (v == '0) ? v : v - TONE_W'(1);
  endfunction

  function automatic logic [COLOR_W-1:0] color_sat_step(input logic [COLOR_W-1:0] v,
                                                        input logic up);
    if (up)
      return (v == '1) ? v : v + COLOR_W'(1);
    return (v == '0) ? v : v - COLOR_W'(1);
  endfunction

  // Both buttons together cancel each other and read as no request.
  assign up_req   = UP & ~down;
  assign dn_req   = down & ~UP;
  assign exit_req = dir_up ? ~up_req : ~dn_req;

  always_comb begin
    step    = 1'b0;
    step_up = dir_up;
    case (state)
      IDLE: begin
        if (up_req && !up_hist) begin
          step    = 1'b1;
          step_up = 1'b1;
        end else if (dn_req && !dn_hist) begin
          step    = 1'b1;
          step_up = 1'b0;
        end
      end
      HOLD:    step = !exit_req && (cnt == DLY_LAST);
      RPT:     step = !exit_req && (cnt == PER_LAST);
      default: step = 1'b0;
    endcase
  end

  // Target resolution: tone wins over colour; an out-of-range sel means no target.
  always_comb begin
    tone_nxt   = ton;
    colors_nxt = colors;
    tgt_valid  = 1'b0;
    tgt_moved  = 1'b0;
    if (Tono) begin
      tgt_valid = 1'b1;
      tone_nxt  = tone_sat_step(ton, step_up);
      tgt_moved = (tone_nxt != ton);
    end else if (color) begin
      for (int i = 0; i < NCH; i++) begin
        if (int'(sel) == i) begin
          tgt_valid = 1'b1;
          colors_nxt[i*COLOR_W +: COLOR_W] =
            color_sat_step(colors[i*COLOR_W +: COLOR_W], step_up);
          tgt_moved = (colors_nxt[i*COLOR_W +: COLOR_W] != colors[i*COLOR_W +: COLOR_W]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dir_up   <= 1'b1;
      up_hist  <= up_req;
      dn_hist  <= dn_req;
      ton      <= TONE_RST;
      colors   <= COLOR_RST;
      changed  <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      up_hist  <= up_req;
      dn_hist  <= dn_req;
      changed  <= 1'b0;
      at_limit <= 1'b0;

      case (state)
        IDLE: begin
          if (step) begin
            dir_up <= step_up;
            cnt    <= '0;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (exit_req) begin
            state <= IDLE;
          end else if (step) begin
            cnt   <= '0;
            state <= RPT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RPT: begin
          if (exit_req)
            state <= IDLE;
          else if (step)
            cnt <= '0;
          else
            cnt <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase

      if (step && tgt_valid) begin
        ton      <= tone_nxt;
        colors   <= colors_nxt;
        changed  <= tgt_moved;
        at_limit <= ~tgt_moved;
      end
    end
  end

endmodule

// File: tb/tb_control_croma_multi.sv
// Directed bench for control_croma_multi with short repeat timing (DLY=8, PER=4).
module tb_control_croma_multi;

  logic       clk;
  logic       reset;
  logic       Tono;
  logic       color;
  logic [0:0] sel;
  logic       UP;
  logic       down;
  logic [7:0] ton;
  logic [5:0] colors;
  logic       changed;
  logic       at_limit;

  int errors = 0;
  int checks = 0;

  control_croma_multi #(
    .REPEAT_DLY (8),
    .REPEAT_PER (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Tono     (Tono),
    .color    (color),
    .sel      (sel),
    .UP       (UP),
    .down     (down),
    .ton      (ton),
    .colors   (colors),
    .changed  (changed),
    .at_limit (at_limit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_step(int i);
    return (i == 0) || (i >= 8 && ((i - 8) % 4) == 0);
  endfunction

  task automatic do_reset();
    Tono  = 1'b0;
    color = 1'b0;
    sel   = 1'b0;
    UP    = 1'b0;
    down  = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ton !== 8'hA4) begin errors++; $display("FAIL rst_ton: got %h want a4", ton); end
    checks++;
    if (colors !== 6'b111000) begin errors++; $display("FAIL rst_colors: got %b want 111000", colors); end
    checks++;
    if (changed !== 1'b0 || at_limit !== 1'b0) begin
      errors++; $display("FAIL rst_pulses: got chg=%b lim=%b want 0 0", changed, at_limit);
    end
  endtask

  task automatic test_tone_press();
    do_reset();
    Tono = 1'b1;
    color = 1'b1;
    UP = 1'b1;
    tick();
    checks++;
    if (ton !== 8'hA5) begin errors++; $display("FAIL press_ton: got %h want a5", ton); end
    checks++;
    if (changed !== 1'b1 || at_limit !== 1'b0) begin
      errors++; $display("FAIL press_pulse: got chg=%b lim=%b want 1 0", changed, at_limit);
    end
    UP = 1'b0;
    tick();
    checks++;
    if (changed !== 1'b0 || ton !== 8'hA5) begin
      errors++; $display("FAIL press_after: got chg=%b ton=%h want 0 a5", changed, ton);
    end
    checks++;
    if (colors !== 6'b111000) begin errors++; $display("FAIL press_colors: got %b want 111000", colors); end
  endtask

  task automatic test_no_target();
    do_reset();
    UP = 1'b1;
    tick();
    checks++;
    if (changed !== 1'b0 || at_limit !== 1'b0 || ton !== 8'hA4 || colors !== 6'b111000) begin
      errors++; $display("FAIL notgt: got chg=%b lim=%b ton=%h col=%b want 0 0 a4 111000",
                         changed, at_limit, ton, colors);
    end
    UP = 1'b0;
    tick();
  endtask

  task automatic test_down_floor();
    do_reset();
    color = 1'b1;
    sel   = 1'b0;
    down  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (at_limit !== is_step(i) || changed !== 1'b0 || colors[2:0] !== 3'b000) begin
        errors++; $display("FAIL floor_c%0d: got lim=%b chg=%b ch0=%b want %b 0 000",
                           i, at_limit, changed, colors[2:0], is_step(i));
      end
    end
    down = 1'b0;
    tick();
  endtask

  task automatic test_up_ceiling();
    logic [2:0] exp_c;
    bit         exp_chg;
    bit         exp_lim;
    do_reset();
    color = 1'b1;
    sel   = 1'b1;
    UP    = 1'b1;
    tick();
    checks++;
    if (at_limit !== 1'b1 || changed !== 1'b0 || colors !== 6'b111000) begin
      errors++; $display("FAIL ch1_sat: got lim=%b chg=%b col=%b want 1 0 111000",
                         at_limit, changed, colors);
    end
    UP = 1'b0;
    tick();
    sel   = 1'b0;
    UP    = 1'b1;
    exp_c = 3'b000;
    for (int i = 0; i < 30; i++) begin
      tick();
      exp_chg = is_step(i) && (exp_c != 3'b111);
      exp_lim = is_step(i) && (exp_c == 3'b111);
      if (exp_chg) exp_c = exp_c + 3'd1;
      checks++;
      if (colors[2:0] !== exp_c || changed !== exp_chg || at_limit !== exp_lim || colors[5:3] !== 3'b111) begin
        errors++; $display("FAIL ceil_c%0d: got ch0=%b ch1=%b chg=%b lim=%b want %b 111 %b %b",
                           i, colors[2:0], colors[5:3], changed, at_limit, exp_c, exp_chg, exp_lim);
      end
    end
    UP = 1'b0;
    tick();
  endtask

  task automatic test_tone_saturate();
    do_reset();
    Tono = 1'b1;
    for (int i = 0; i < 90; i++) begin
      UP = 1'b1;
      tick();
      UP = 1'b0;
      tick();
    end
    checks++;
    if (ton !== 8'hFE) begin errors++; $display("FAIL tone_preset: got %h want fe", ton); end
    UP = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (ton !== 8'hFF || changed !== (i == 0) || at_limit !== (is_step(i) && i != 0)) begin
        errors++; $display("FAIL tone_sat_c%0d: got ton=%h chg=%b lim=%b want ff %b %b",
                           i, ton, changed, at_limit, (i == 0), (is_step(i) && i != 0));
      end
    end
    UP = 1'b0;
    tick();
  endtask

  task automatic test_both_buttons();
    do_reset();
    Tono = 1'b1;
    UP   = 1'b1;
    down = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (changed !== 1'b0 || at_limit !== 1'b0 || ton !== 8'hA4) begin
        errors++; $display("FAIL both_c%0d: got chg=%b lim=%b ton=%h want 0 0 a4",
                           i, changed, at_limit, ton);
      end
    end
    down = 1'b0;
    tick();
    checks++;
    if (changed !== 1'b1 || ton !== 8'hA5) begin
      errors++; $display("FAIL both_release: got chg=%b ton=%h want 1 a5", changed, ton);
    end
    tick();
    checks++;
    if (changed !== 1'b0 || ton !== 8'hA5) begin
      errors++; $display("FAIL both_after: got chg=%b ton=%h want 0 a5", changed, ton);
    end
    UP = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_hold();
    logic [7:0] exp_t;
    bit         exp_chg;
    do_reset();
    Tono  = 1'b1;
    UP    = 1'b1;
    exp_t = 8'hA4;
    for (int i = 0; i < 20; i++) begin
      reset = (i == 10 || i == 11);
      tick();
      if (i >= 10) begin
        exp_t   = 8'hA4;
        exp_chg = 1'b0;
      end else begin
        exp_chg = is_step(i);
        if (exp_chg) exp_t = exp_t + 8'd1;
      end
      checks++;
      if (ton !== exp_t || changed !== exp_chg || at_limit !== 1'b0) begin
        errors++; $display("FAIL rsthold_c%0d: got ton=%h chg=%b lim=%b want %h %b 0",
                           i, ton, changed, at_limit, exp_t, exp_chg);
      end
    end
    reset = 1'b0;
    UP = 1'b0;
    tick();
    checks++;
    if (changed !== 1'b0 || ton !== 8'hA4) begin
      errors++; $display("FAIL rsthold_rel: got chg=%b ton=%h want 0 a4", changed, ton);
    end
    UP = 1'b1;
    tick();
    checks++;
    if (changed !== 1'b1 || ton !== 8'hA5) begin
      errors++; $display("FAIL rsthold_repress: got chg=%b ton=%h want 1 a5", changed, ton);
    end
    UP = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    Tono  = 1'b0;
    color = 1'b0;
    sel   = 1'b0;
    UP    = 1'b0;
    down  = 1'b0;
    test_reset();
    test_tone_press();
    test_no_target();
    test_down_floor();
    test_up_ceiling();
    test_tone_saturate();
    test_both_buttons();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
